// File: rtl/tagger_pkg.sv
// rtl/tagger_pkg.sv - shared PatID helpers, budget/charge types and default AXI structs
package tagger_pkg;

  localparam int CHARGE_W = 10;
  localparam int DEFAULT_BUDGET_W = 16;
  localparam int DEFAULT_PERIOD_W = 16;

  typedef logic [CHARGE_W-1:0]         charge_t;
  typedef logic [DEFAULT_BUDGET_W-1:0] budget_t;
  typedef logic [DEFAULT_PERIOD_W-1:0] period_t;

  function automatic int patid_width(input int msb, input int lsb);
    return msb - lsb + 1;
  endfunction

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [7:0]  user;
  } tagger_axi_ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } tagger_axi_w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } tagger_axi_b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } tagger_axi_r_t;

  typedef struct packed {
    tagger_axi_ax_t aw;
    logic           aw_valid;
    tagger_axi_w_t  w;
    logic           w_valid;
    logic           b_ready;
    tagger_axi_ax_t ar;
    logic           ar_valid;
    logic           r_ready;
  } tagger_axi_req_t;

  typedef struct packed {
    logic          aw_ready;
    logic          ar_ready;
    logic          w_ready;
    tagger_axi_b_t b;
    logic          b_valid;
    tagger_axi_r_t r;
    logic          r_valid;
  } tagger_axi_rsp_t;

endpackage

// File: rtl/tagger_bw_budget.sv
// rtl/tagger_bw_budget.sv - one partition's beat budget with saturating charge and refill
module tagger_bw_budget
  import tagger_pkg::*;
#(
  parameter int BUDGET_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    refill,
  input  logic                    regulated,
  input  logic [BUDGET_WIDTH-1:0] limit,
  input  charge_t                 charge,
  output logic                    nonzero,
  output logic                    throttle
);

  localparam int EW = (BUDGET_WIDTH > CHARGE_W) ? BUDGET_WIDTH : CHARGE_W;

  logic [BUDGET_WIDTH-1:0] budget_q;
  logic [BUDGET_WIDTH-1:0] budget_d;
  logic [EW-1:0]           budget_ext;
  logic [EW-1:0]           charge_ext;

  // Refill wins over a same-cycle charge, so that charge is forgiven.
  always_comb begin
    budget_ext = EW'(budget_q);
    charge_ext = EW'(charge);
    budget_d   = budget_q;
    if (refill) begin
      budget_d = limit;
    end else if (regulated) begin
      budget_d = (charge_ext >= budget_ext) ? '0 : BUDGET_WIDTH'(budget_ext - charge_ext);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      budget_q <= '0;
      throttle <= 1'b0;
    end else begin
      budget_q <= budget_d;
      throttle <= regulated && (budget_d == '0);
    end
  end

  assign nonzero = |budget_q;

endmodule

// File: rtl/tagger_bw_regulator.sv
// rtl/tagger_bw_regulator.sv - per-partition AR/AW beat-budget gate in front of the LLC port
module tagger_bw_regulator
  import tagger_pkg::*;
#(
  parameter int  MAXPARTITION    = 16,
  parameter int  AXI_USER_ID_MSB = 7,
  parameter int  AXI_USER_ID_LSB = 0,
  parameter int  BUDGET_WIDTH    = 16,
  parameter int  PERIOD_WIDTH    = 16,
  parameter type axi_req_t       = tagger_axi_req_t,
  parameter type axi_rsp_t       = tagger_axi_rsp_t
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  axi_req_t                                 slv_req_i,
  output axi_rsp_t                                 slv_rsp_o,
  output axi_req_t                                 mst_req_o,
  input  axi_rsp_t                                 mst_rsp_i,
  input  logic                                     enable_i,
  input  logic [PERIOD_WIDTH-1:0]                  period_i,
  input  logic [MAXPARTITION-1:0][BUDGET_WIDTH-1:0] budget_i,
  output logic [MAXPARTITION-1:0]                  throttle_o
);

  localparam int PW = patid_width(AXI_USER_ID_MSB, AXI_USER_ID_LSB);

  logic [PW-1:0]           ar_pid, aw_pid;
  logic [MAXPARTITION-1:0] regulated, nonzero;
  logic                    ar_reg, ar_nz, aw_reg, aw_nz;
  logic                    allow_ar, allow_aw;
  logic                    ar_fwd, aw_fwd, ar_hs, aw_hs;
  logic                    ar_hold_q, aw_hold_q;
  charge_t                 ar_cost, aw_cost;
  charge_t                 charge [MAXPARTITION];
  logic [PERIOD_WIDTH-1:0] period_cnt, period_last;
  logic                    refill;

  assign ar_pid = slv_req_i.ar.user[AXI_USER_ID_MSB:AXI_USER_ID_LSB];
  assign aw_pid = slv_req_i.aw.user[AXI_USER_ID_MSB:AXI_USER_ID_LSB];

  // PatIDs at or above MAXPARTITION never match, so they are never gated or charged.
  always_comb begin
    ar_reg = 1'b0;
    ar_nz  = 1'b0;
    aw_reg = 1'b0;
    aw_nz  = 1'b0;
    for (int p = 0; p < MAXPARTITION; p++) begin
      regulated[p] = enable_i && (budget_i[p] != '0);
      if (int'(ar_pid) == p) begin
        ar_reg = regulated[p];
        ar_nz  = nonzero[p];
      end
      if (int'(aw_pid) == p) begin
        aw_reg = regulated[p];
        aw_nz  = nonzero[p];
      end
    end
  end

  assign allow_ar = !ar_reg || ar_nz || ar_hold_q;
  assign allow_aw = !aw_reg || aw_nz || aw_hold_q;
  assign ar_fwd   = slv_req_i.ar_valid & allow_ar;
  assign aw_fwd   = slv_req_i.aw_valid & allow_aw;
  assign ar_hs    = ar_fwd & mst_rsp_i.ar_ready;
  assign aw_hs    = aw_fwd & mst_rsp_i.aw_ready;

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.ar_valid = ar_fwd;
    mst_req_o.aw_valid = aw_fwd;
    slv_rsp_o          = mst_rsp_i;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & allow_ar;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & allow_aw;
  end

  assign ar_cost = charge_t'(slv_req_i.ar.len) + charge_t'(1);
  assign aw_cost = charge_t'(slv_req_i.aw.len) + charge_t'(1);

  always_comb begin
    for (int p = 0; p < MAXPARTITION; p++) begin
      charge[p] = ((ar_hs && int'(ar_pid) == p) ? ar_cost : '0)
                + ((aw_hs && int'(aw_pid) == p) ? aw_cost : '0);
    end
  end

  assign period_last = (period_i == '0) ? '0 : period_i - PERIOD_WIDTH'(1);
  assign refill      = enable_i && (period_cnt == '0);

  // Hold flops keep a forwarded valid asserted until its handshake even if the budget drains.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      period_cnt <= '0;
      ar_hold_q  <= 1'b0;
      aw_hold_q  <= 1'b0;
    end else begin
      if (!enable_i || period_cnt >= period_last) begin
        period_cnt <= '0;
      end else begin
        period_cnt <= period_cnt + PERIOD_WIDTH'(1);
      end
      if (ar_hs) begin
        ar_hold_q <= 1'b0;
      end else if (ar_fwd) begin
        ar_hold_q <= 1'b1;
      end
      if (aw_hs) begin
        aw_hold_q <= 1'b0;
      end else if (aw_fwd) begin
        aw_hold_q <= 1'b1;
      end
    end
  end

  for (genvar p = 0; p < MAXPARTITION; p++) begin : g_budget
    tagger_bw_budget #(
      .BUDGET_WIDTH(BUDGET_WIDTH)
    ) u_budget (
      .clk      (clk_i),
      .rst      (rst_i),
      .refill   (refill),
      .regulated(regulated[p]),
      .limit    (budget_i[p]),
      .charge   (charge[p]),
      .nonzero  (nonzero[p]),
      .throttle (throttle_o[p])
    );
  end

endmodule

// File: tb/tb_tagger_bw_regulator.sv
// tb/tb_tagger_bw_regulator.sv - directed self-checking bench for tagger_bw_regulator
module tb_tagger_bw_regulator;
  import tagger_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  enable;
  logic [15:0]           period;
  logic [15:0][15:0]     budget;
  logic [15:0]           throttle;
  tagger_axi_req_t       slv_req, mst_req;
  tagger_axi_rsp_t       slv_rsp, mst_rsp;

  int checks   = 0;
  int failures = 0;
  int stall, thr, hold_bad;

  always #5 clk = ~clk;

  tagger_bw_regulator #(
    .axi_req_t(tagger_axi_req_t),
    .axi_rsp_t(tagger_axi_rsp_t)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .slv_req_i (slv_req),
    .slv_rsp_o (slv_rsp),
    .mst_req_o (mst_req),
    .mst_rsp_i (mst_rsp),
    .enable_i  (enable),
    .period_i  (period),
    .budget_i  (budget),
    .throttle_o(throttle)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ar(input logic v, input logic [7:0] pid, input logic [7:0] len);
    slv_req.ar_valid = v;
    slv_req.ar.user  = pid;
    slv_req.ar.len   = len;
  endtask

  task automatic set_aw(input logic v, input logic [7:0] pid, input logic [7:0] len);
    slv_req.aw_valid = v;
    slv_req.aw.user  = pid;
    slv_req.aw.len   = len;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_ar(1'b0, 8'd0, 8'd0);
    set_aw(1'b0, 8'd0, 8'd0);
    tick();
    rst = 1'b0;
  endtask

  task automatic run_pass(input logic [7:0] pid, output int stalls, output int thr_cnt);
    stalls  = 0;
    thr_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      set_ar(1'b1, pid, 8'(i % 8));
      set_aw(1'b1, pid, 8'(i % 8));
      #1;
      if (!(mst_req.ar_valid && slv_rsp.ar_ready && mst_req.aw_valid && slv_rsp.aw_ready)) stalls++;
      if (throttle != '0) thr_cnt++;
      tick();
    end
    set_ar(1'b0, 8'd0, 8'd0);
    set_aw(1'b0, 8'd0, 8'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    enable  = 1'b0;
    period  = 16'd100;
    budget  = '0;
    slv_req = '0;
    mst_rsp = '0;
    mst_rsp.ar_ready = 1'b1;
    mst_rsp.aw_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // reset state and passthrough with regulation off
    slv_req.ar.addr  = 32'h0000_1234;
    slv_req.w.data   = 32'h5555_AAAA;
    mst_rsp.r.data   = 32'h0000_CAFE;
    mst_rsp.r_valid  = 1'b1;
    set_ar(1'b1, 8'd3, 8'd1);
    #1;
    chk("reset_throttle", 64'(throttle), 64'd0);
    chk("disabled_ar_valid", 64'(mst_req.ar_valid), 64'd1);
    chk("disabled_ar_ready", 64'(slv_rsp.ar_ready), 64'd1);
    chk("pass_ar_addr", 64'(mst_req.ar.addr), 64'h1234);
    chk("pass_w_data", 64'(mst_req.w.data), 64'h5555_AAAA);
    chk("pass_r_data", 64'(slv_rsp.r.data), 64'hCAFE);
    chk("pass_r_valid", 64'(slv_rsp.r_valid), 64'd1);

    // budget 8, period 100, partition 3: four len=1 bursts, then 96 stall cycles
    enable    = 1'b1;
    period    = 16'd100;
    budget[3] = 16'd8;
    do_reset();
    set_ar(1'b1, 8'd3, 8'd1);
    #1;
    chk("t1_first_block_valid", 64'(mst_req.ar_valid), 64'd0);
    chk("t1_first_block_ready", 64'(slv_rsp.ar_ready), 64'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t1_accept", 64'(mst_req.ar_valid), 64'd1);
      tick();
    end
    stall = 0;
    thr   = 0;
    while (!mst_req.ar_valid && stall < 300) begin
      if (!throttle[3]) thr++;
      tick();
      stall++;
    end
    chk("t1_stall_cycles", 64'(stall), 64'd96);
    chk("t1_throttle_during_stall", 64'(thr), 64'd0);
    chk("t1_throttle_released", 64'(throttle[3]), 64'd0);
    tick();
    set_ar(1'b0, 8'd0, 8'd0);

    // AR len=7 and AW len=3 together against budget 10
    budget[3] = 16'd0;
    budget[2] = 16'd10;
    do_reset();
    tick();
    set_ar(1'b1, 8'd2, 8'd7);
    set_aw(1'b1, 8'd2, 8'd3);
    #1;
    chk("t2_ar_accept", 64'(mst_req.ar_valid), 64'd1);
    chk("t2_aw_accept", 64'(mst_req.aw_valid), 64'd1);
    tick();
    set_aw(1'b0, 8'd0, 8'd0);
    set_ar(1'b1, 8'd2, 8'd0);
    #1;
    chk("t2_next_ar_stall", 64'(mst_req.ar_valid), 64'd0);
    chk("t2_throttle", 64'(throttle[2]), 64'd1);

    // AW drains the budget while a forwarded AR waits on backpressure
    budget[2] = 16'd4;
    do_reset();
    tick();
    mst_rsp.ar_ready = 1'b0;
    set_ar(1'b1, 8'd2, 8'd0);
    set_aw(1'b1, 8'd2, 8'd3);
    #1;
    chk("t3_ar_fwd", 64'(mst_req.ar_valid), 64'd1);
    chk("t3_aw_fwd", 64'(mst_req.aw_valid), 64'd1);
    tick();
    set_aw(1'b0, 8'd0, 8'd0);
    #1;
    hold_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (!mst_req.ar_valid) hold_bad++;
      tick();
    end
    chk("t3_hold_valid", 64'(hold_bad), 64'd0);
    chk("t3_throttle", 64'(throttle[2]), 64'd1);
    mst_rsp.ar_ready = 1'b1;
    #1;
    chk("t3_handshake_ready", 64'(slv_rsp.ar_ready), 64'd1);
    tick();
    chk("t3_after_hs_block", 64'(mst_req.ar_valid), 64'd0);
    set_ar(1'b0, 8'd0, 8'd0);

    // handshake in the refill cycle is forgiven (period 4, budget 5)
    budget[2] = 16'd0;
    budget[6] = 16'd5;
    period    = 16'd4;
    do_reset();
    repeat (4) tick();
    set_ar(1'b1, 8'd6, 8'd3);
    #1;
    chk("t4_refill_cycle_hs", 64'(mst_req.ar_valid), 64'd1);
    tick();
    chk("t4_after_refill", 64'(mst_req.ar_valid), 64'd1);
    tick();
    set_ar(1'b1, 8'd6, 8'd0);
    #1;
    chk("t4_one_left", 64'(mst_req.ar_valid), 64'd1);
    tick();
    chk("t4_drained", 64'(mst_req.ar_valid), 64'd0);
    chk("t4_throttle", 64'(throttle[6]), 64'd1);
    tick();
    chk("t4_refill_still_block", 64'(mst_req.ar_valid), 64'd0);
    tick();
    chk("t4_refilled", 64'(mst_req.ar_valid), 64'd1);
    set_ar(1'b0, 8'd0, 8'd0);

    // unregulated traffic: zero budget, out-of-range PatID, enable low
    period = 16'd100;
    for (int p = 0; p < 16; p++) budget[p] = 16'd3;
    budget[5] = 16'd0;
    do_reset();
    run_pass(8'd5, stall, thr);
    chk("t5_zero_budget_stalls", 64'(stall), 64'd0);
    chk("t5_zero_budget_throttle", 64'(thr), 64'd0);
    run_pass(8'd20, stall, thr);
    chk("t5_pid20_stalls", 64'(stall), 64'd0);
    chk("t5_pid20_throttle", 64'(thr), 64'd0);
    budget[5] = 16'd8;
    enable    = 1'b0;
    tick();
    run_pass(8'd5, stall, thr);
    chk("t5_disabled_stalls", 64'(stall), 64'd0);
    chk("t5_disabled_throttle", 64'(thr), 64'd0);

    // reset while partition 1 is throttled
    enable = 1'b1;
    budget = '0;
    budget[1] = 16'd2;
    do_reset();
    tick();
    set_ar(1'b1, 8'd1, 8'd1);
    #1;
    chk("t6_accept", 64'(mst_req.ar_valid), 64'd1);
    tick();
    chk("t6_throttled", 64'(throttle[1]), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_reset_throttle", 64'(throttle), 64'd0);
    chk("t6_first_block", 64'(mst_req.ar_valid), 64'd0);
    tick();
    chk("t6_refill_allow", 64'(mst_req.ar_valid), 64'd1);
    set_ar(1'b0, 8'd0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
